// File: rtl/wide_alu_pkg.sv
// Shared types for the sequential wide ALU: opcodes, FSM states, slice width
// and the response flag bundle.
package wide_alu_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [2:0] {
    OP_NOT = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic cf;
    logic zf;
    logic err;
  } rsp_flags_t;

  // Opcodes 11x are the only illegal encodings.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/wide_alu_seq_alu4.sv
// 4-bit combinational ALU slice: m=0 selects logic ops by s, m=1 selects
// ADD (s=00) or SUB with borrow (s=01).
module wide_alu_seq_alu4
  import wide_alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic [1:0]         s,
  input  logic               m,
  output logic [SLICE_W-1:0] c,
  output logic               cf,
  output logic               zf
);

  logic [SLICE_W:0] sum_c;
  logic [SLICE_W:0] diff_c;

  // Bit SLICE_W of the 5-bit difference is set exactly when a < b + cin.
  always_comb begin
    sum_c  = {1'b0, a} + {1'b0, b} + (SLICE_W + 1)'(cin);
    diff_c = {1'b0, a} - {1'b0, b} - (SLICE_W + 1)'(cin);
    c      = '0;
    cf     = 1'b0;
    case ({m, s})
      3'b000: c = ~a;
      3'b001: c = a & b;
      3'b010: c = a | b;
      3'b011: c = a ^ b;
      3'b100: begin
        c  = sum_c[SLICE_W-1:0];
        cf = sum_c[SLICE_W];
      end
      3'b101: begin
        c  = diff_c[SLICE_W-1:0];
        cf = diff_c[SLICE_W];
      end
      default: ;
    endcase
  end

  assign zf = (c == '0);

endmodule

// File: rtl/wide_alu_seq.sv
// Sequential W-bit ALU: one request is processed a nibble per cycle through a
// single 4-bit slice, LSB first, with carry/borrow chained between cycles.
module wide_alu_seq
  import wide_alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_op,
  input  logic [SLICE_W*NIBBLES-1:0]   req_a,
  input  logic [SLICE_W*NIBBLES-1:0]   req_b,
  input  logic                         req_cin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [SLICE_W*NIBBLES-1:0]   rsp_y,
  output logic                         rsp_cf,
  output logic                         rsp_zf,
  output logic                         rsp_err
);

  localparam int unsigned W        = SLICE_W * NIBBLES;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     y_q, y_d;
  rsp_flags_t       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic               accept_c;
  logic               legal_c;
  logic               last_c;
  logic [SLICE_W-1:0] slice_a_c;
  logic [SLICE_W-1:0] slice_b_c;
  logic [SLICE_W-1:0] slice_y_c;
  logic               slice_cf_c;
  logic               slice_zf_c;
  logic               slice_m_c;
  logic [1:0]         slice_s_c;

  assign accept_c = req_valid && ready_q;
  assign legal_c  = op_is_legal(req_op);
  assign last_c   = (idx_q == LAST_IDX);

  assign slice_a_c = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
  assign slice_b_c = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

  // Mode decode never produces m=1 with s=1x, even when an illegal op is held.
  assign slice_m_c = op_is_arith(op_q);
  assign slice_s_c = slice_m_c ? {1'b0, (op_q == OP_SUB)} : op_q[1:0];

  wide_alu_seq_alu4 u_alu4 (
    .a   (slice_a_c),
    .b   (slice_b_c),
    .cin (carry_q),
    .s   (slice_s_c),
    .m   (slice_m_c),
    .c   (slice_y_c),
    .cf  (slice_cf_c),
    .zf  (slice_zf_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = legal_c ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (valid_q && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-values.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    flags_d = flags_q;
    valid_d = valid_q;
    ready_d = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d        = req_op;
          a_d         = req_a;
          b_d         = req_b;
          idx_d       = '0;
          carry_d     = op_is_arith(req_op) ? req_cin : 1'b0;
          y_d         = '0;
          // zf starts set for legal ops and is ANDed with every slice result.
          flags_d.cf  = 1'b0;
          flags_d.zf  = legal_c;
          flags_d.err = !legal_c;
          valid_d     = 1'b0;
        end
      end
      ST_RUN: begin
        y_d[SLICE_W*int'(idx_q) +: SLICE_W] = slice_y_c;
        carry_d    = slice_cf_c;
        flags_d.zf = flags_q.zf & slice_zf_c;
        idx_d      = idx_q + IDX_W'(1);
        if (last_c) begin
          idx_d      = '0;
          flags_d.cf = slice_cf_c;
          valid_d    = 1'b1;
        end
      end
      ST_DONE: begin
        // An illegal op enters DONE with valid low; it rises one cycle later.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (rsp_ready) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_y     = y_q;
  assign rsp_cf    = flags_q.cf;
  assign rsp_zf    = flags_q.zf;
  assign rsp_err   = flags_q.err;

endmodule
